// File: rtl/cpu_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_fsm -- multi-cycle control sequencer for the 16-bit CPU datapath.
//
// Walks each instruction through FETCH, DECODE, EXECUTE, MEM and WB, driving
// the register-file write enable, the memory request and the write-back
// select.  It handshakes with a variable-latency shared memory port.
//
// Optional feature macro: CPU_CTRL_PERF_CNT_EN
//   defined   -> cycle_cnt / retired_cnt performance counters are live
//   undefined -> both counters are tied to zero and carry no flops
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   start        in   leave IDLE and begin fetching
//   opcode       in   opcode from the instruction register
//   mem_ack      in   memory completes the current request this cycle
//   mem_req      out  memory request, held until mem_ack
//   mem_we       out  request is a write (ST)
//   addr_sel     out  0 = address from PC, 1 = address from ALU result
//   ir_load      out  capture memory read data into the instruction register
//   pc_inc       out  PC <= PC + 1
//   alu_op       out  opcode presented to the ALU (latched in DECODE)
//   rf_we        out  register-file write enable
//   wb_sel       out  0 = write back ALU result, 1 = memory data
//   busy         out  state is neither IDLE nor HALT
//   halted       out  in HALT
//   illegal_op   out  one-cycle pulse on an undefined opcode
//   cycle_cnt    out  cycles spent while busy
//   retired_cnt  out  instructions completed
// ---------------------------------------------------------------------------
module cpu_ctrl_fsm #(
  parameter int                  OPCODE_W = 6,
  parameter logic [OPCODE_W-1:0] HALT_OP  = 6'h3F,
  parameter int                  CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic                addr_sel,
  output logic                ir_load,
  output logic                pc_inc,
  output logic [OPCODE_W-1:0] alu_op,
  output logic                rf_we,
  output logic                wb_sel,
  output logic                busy,
  output logic                halted,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    retired_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_ARITH_MAX = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_LD        = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_ST        = OPCODE_W'(9);

  // Opcode classification helpers.
  function automatic logic is_arith(input logic [OPCODE_W-1:0] op);
    return (op <= OP_ARITH_MAX);
  endfunction

  function automatic logic is_illegal(input logic [OPCODE_W-1:0] op);
    return !(is_arith(op) || (op == OP_LD) || (op == OP_ST) || (op == HALT_OP));
  endfunction

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] alu_op_q, alu_op_d;
  logic mem_req_q, mem_req_d;
  logic mem_we_q, mem_we_d;
  logic addr_sel_q, addr_sel_d;
  logic rf_we_q, rf_we_d;
  logic wb_sel_q, wb_sel_d;
  logic busy_q, busy_d;
  logic halted_q, halted_d;
  logic illegal_op_q, illegal_op_d;

  // Next-state logic plus Moore output decode of the *next* state, so the
  // registered outputs line up with the state they describe.
  always_comb begin
    state_d  = state_q;
    alu_op_d = alu_op_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
        else       state_d = S_IDLE;
      end
      S_FETCH: begin
        if (mem_ack) state_d = S_DECODE;
        else         state_d = S_FETCH;
      end
      S_DECODE: begin
        alu_op_d = opcode;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        if (is_arith(alu_op_q))                              state_d = S_WB;
        else if ((alu_op_q == OP_LD) || (alu_op_q == OP_ST)) state_d = S_MEM;
        else if (alu_op_q == HALT_OP)                        state_d = S_HALT;
        else                                                 state_d = S_FETCH; // illegal: NOP
      end
      S_MEM: begin
        if (mem_ack) begin
          if (alu_op_q == OP_ST) state_d = S_FETCH;  // stores retire on ack
          else                   state_d = S_WB;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    mem_req_d    = (state_d == S_FETCH) || (state_d == S_MEM);
    mem_we_d     = (state_d == S_MEM) && (alu_op_d == OP_ST);
    addr_sel_d   = (state_d == S_MEM);
    rf_we_d      = (state_d == S_WB);
    wb_sel_d     = (state_d == S_WB) && (alu_op_d == OP_LD);
    busy_d       = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d     = (state_d == S_HALT);
    illegal_op_d = (state_d == S_EXEC) && is_illegal(alu_op_d);
  end

  // State, latched opcode and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      alu_op_q     <= {OPCODE_W{1'b0}};
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      addr_sel_q   <= 1'b0;
      rf_we_q      <= 1'b0;
      wb_sel_q     <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      illegal_op_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_op_q     <= alu_op_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      addr_sel_q   <= addr_sel_d;
      rf_we_q      <= rf_we_d;
      wb_sel_q     <= wb_sel_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
      illegal_op_q <= illegal_op_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign addr_sel   = addr_sel_q;
  assign alu_op     = alu_op_q;
  assign rf_we      = rf_we_q;
  assign wb_sel     = wb_sel_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign illegal_op = illegal_op_q;

  // The fetch strobes must fire in the ack cycle itself, so they are the only
  // combinational outputs; reset still suppresses them.
  assign ir_load = (state_q == S_FETCH) && mem_ack && !reset;
  assign pc_inc  = (state_q == S_FETCH) && mem_ack && !reset;

`ifdef CPU_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
  logic             retire;

  // Completion events: WB exit, store ack, and the illegal EXECUTE cycle.
  always_comb begin
    retire = 1'b0;
    if (state_q == S_WB) begin
      retire = 1'b1;
    end else if ((state_q == S_MEM) && mem_ack && (alu_op_q == OP_ST)) begin
      retire = 1'b1;
    end else if ((state_q == S_EXEC) && is_illegal(alu_op_q)) begin
      retire = 1'b1;
    end else begin
      retire = 1'b0;
    end
    cycle_cnt_d   = cycle_cnt_q   + {{(CNT_W-1){1'b0}}, busy_q};
    retired_cnt_d = retired_cnt_q + {{(CNT_W-1){1'b0}}, retire};
  end

  // Performance counters; wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q   <= {CNT_W{1'b0}};
      retired_cnt_q <= {CNT_W{1'b0}};
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign retired_cnt = retired_cnt_q;
`else
  assign cycle_cnt   = {CNT_W{1'b0}};
  assign retired_cnt = {CNT_W{1'b0}};
`endif

endmodule
